// File: rtl/counter4_monitor.sv
// counter4_monitor: receive-side checker for the 4-bit en/rst pulse counter
//
// Ports:
//   GCLK_Pad      in   system clock, rising edge
//   rst_n_Pad     in   synchronous active-low reset
//   en_Pad        in   counter enable pulse seen by the counter this cycle
//   ctr_rst_Pad   in   counter reset pulse seen by the counter this cycle
//   chk_en_Pad    in   1 = compare, 0 = model tracks without comparing
//   count_Pad     in   count value returned by the counter (LAT cycles late)
//   locked_Pad    out  model synchronised to the counter
//   exp_Pad       out  current model value
//   mismatch_Pad  out  one-cycle pulse per failed compare
//   fail_Pad      out  sticky, set on first mismatch
//   err_cnt_Pad   out  saturating mismatch count
//   first_exp_Pad out  expected value of first mismatch
//   first_act_Pad out  actual value of first mismatch
module counter4_monitor #(
   parameter int WIDTH = 4,
   parameter int LAT   = 1,
   parameter int ERRW  = 8
) (
   input  logic             GCLK_Pad,
   input  logic             rst_n_Pad,
   input  logic             en_Pad,
   input  logic             ctr_rst_Pad,
   input  logic             chk_en_Pad,
   input  logic [WIDTH-1:0] count_Pad,
   output logic             locked_Pad,
   output logic [WIDTH-1:0] exp_Pad,
   output logic             mismatch_Pad,
   output logic             fail_Pad,
   output logic [ERRW-1:0]  err_cnt_Pad,
   output logic [WIDTH-1:0] first_exp_Pad,
   output logic [WIDTH-1:0] first_act_Pad
);
   typedef enum logic {SYNC, TRACK} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [WIDTH-1:0] pipe_q [LAT];
   logic [WIDTH-1:0] pipe_d [LAT];
   logic [LAT-1:0]   pv_q, pv_d;
   logic             mis_q, mis_d;
   logic             fail_q, fail_d;
   logic [ERRW-1:0]  err_q, err_d;
   logic [WIDTH-1:0] fe_q, fe_d;
   logic [WIDTH-1:0] fa_q, fa_d;
   logic             track, push_v, bad;
   always_comb begin
      track   = state_q == TRACK;
      // a ctr_rst seen in SYNC both locks the model and pushes a valid 0
      push_v  = track | ctr_rst_Pad;
      state_d = push_v ? TRACK : SYNC;
      exp_d   = ctr_rst_Pad ? '0 : (track & en_Pad) ? exp_q + WIDTH'(1) : exp_q;
      pipe_d[0] = exp_d;
      pv_d[0]   = push_v;
      for (int k = 1; k < LAT; k++) begin
         pipe_d[k] = pipe_q[k-1];
         pv_d[k]   = pv_q[k-1];
      end
      // the oldest stage lines up with the value now on count_Pad
      bad    = pv_q[LAT-1] & chk_en_Pad & (pipe_q[LAT-1] != count_Pad);
      mis_d  = bad;
      err_d  = (bad && err_q != '1) ? err_q + ERRW'(1) : err_q;
      fail_d = fail_q | bad;
      fe_d   = (bad & ~fail_q) ? pipe_q[LAT-1] : fe_q;
      fa_d   = (bad & ~fail_q) ? count_Pad : fa_q;
   end
   always_ff @(posedge GCLK_Pad) begin
      if (!rst_n_Pad) begin
         state_q <= SYNC;
         exp_q   <= '0;
         pipe_q  <= '{default: '0};
         pv_q    <= '0;
         mis_q   <= 1'b0;
         fail_q  <= 1'b0;
         err_q   <= '0;
         fe_q    <= '0;
         fa_q    <= '0;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         pipe_q  <= pipe_d;
         pv_q    <= pv_d;
         mis_q   <= mis_d;
         fail_q  <= fail_d;
         err_q   <= err_d;
         fe_q    <= fe_d;
         fa_q    <= fa_d;
      end
   end
   assign locked_Pad    = state_q == TRACK;
   assign exp_Pad       = exp_q;
   assign mismatch_Pad  = mis_q;
   assign fail_Pad      = fail_q;
   assign err_cnt_Pad   = err_q;
   assign first_exp_Pad = fe_q;
   assign first_act_Pad = fa_q;
endmodule

// File: tb/tb_counter4_monitor.sv
// tb_counter4_monitor: three monitor instances (LAT1/ERRW8, LAT1/ERRW2, LAT3/ERRW8) against a history-based model
module tb_counter4_monitor;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0, en = 1'b0, crst = 1'b0, chk = 1'b1;
   logic [3:0] cnt [3];
   logic       lk [3], ms [3], fl [3];
   logic [3:0] ex [3], fe [3], fa [3];
   logic [7:0] ec0, ec2;
   logic [1:0] ec1;
   always #5 clk = ~clk;
   counter4_monitor #(.WIDTH(4), .LAT(1), .ERRW(8)) u0 (
      .GCLK_Pad(clk), .rst_n_Pad(rst_n), .en_Pad(en), .ctr_rst_Pad(crst), .chk_en_Pad(chk),
      .count_Pad(cnt[0]), .locked_Pad(lk[0]), .exp_Pad(ex[0]), .mismatch_Pad(ms[0]),
      .fail_Pad(fl[0]), .err_cnt_Pad(ec0), .first_exp_Pad(fe[0]), .first_act_Pad(fa[0]));
   counter4_monitor #(.WIDTH(4), .LAT(1), .ERRW(2)) u1 (
      .GCLK_Pad(clk), .rst_n_Pad(rst_n), .en_Pad(en), .ctr_rst_Pad(crst), .chk_en_Pad(chk),
      .count_Pad(cnt[1]), .locked_Pad(lk[1]), .exp_Pad(ex[1]), .mismatch_Pad(ms[1]),
      .fail_Pad(fl[1]), .err_cnt_Pad(ec1), .first_exp_Pad(fe[1]), .first_act_Pad(fa[1]));
   counter4_monitor #(.WIDTH(4), .LAT(3), .ERRW(8)) u2 (
      .GCLK_Pad(clk), .rst_n_Pad(rst_n), .en_Pad(en), .ctr_rst_Pad(crst), .chk_en_Pad(chk),
      .count_Pad(cnt[2]), .locked_Pad(lk[2]), .exp_Pad(ex[2]), .mismatch_Pad(ms[2]),
      .fail_Pad(fl[2]), .err_cnt_Pad(ec2), .first_exp_Pad(fe[2]), .first_act_Pad(fa[2]));
   localparam int LATS [3] = '{1, 1, 3};
   localparam int EMAX [3] = '{255, 3, 255};
   int hist [3][8192];
   int hn [3];
   int m_exp [3], m_err [3], m_fe [3], m_fa [3];
   bit m_lk [3], m_ms [3], m_fl [3];
   int total = 0, bad = 0;
   typedef struct {
      bit en, cr, ck;
      int cnt, e_exp;
      bit e_lk, e_ms;
      int e_err, e_fe, e_fa;
   } vec_t;
   vec_t tv [15];
   function automatic int correct(int i);
      return (hn[i] >= LATS[i]) ? hist[i][hn[i]-LATS[i]] : -1;
   endfunction
   // mode >= 0: literal value; -1: value the counter should show; -2: corrupted value
   function automatic logic [3:0] pick(int i, int mode);
      int w = correct(i);
      logic [3:0] v;
      if (mode >= 0) return mode[3:0];
      if (w < 0) return 4'($urandom_range(15));
      v = w[3:0];
      return (mode == -1) ? v : v ^ 4'd5;
   endfunction
   task automatic model_edge();
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            hn[i] = 0; m_exp[i] = 0; m_err[i] = 0; m_fe[i] = 0; m_fa[i] = 0;
            m_lk[i] = 0; m_ms[i] = 0; m_fl[i] = 0;
         end else begin
            int w = correct(i);
            m_ms[i] = (w >= 0) && chk && (w != int'(cnt[i]));
            if (m_ms[i]) begin
               if (m_err[i] < EMAX[i]) m_err[i]++;
               if (!m_fl[i]) begin m_fe[i] = w; m_fa[i] = int'(cnt[i]); m_fl[i] = 1; end
            end
            if (m_lk[i] || crst) begin
               m_exp[i] = crst ? 0 : en ? (m_exp[i] + 1) % 16 : m_exp[i];
               m_lk[i] = 1;
               hist[i][hn[i]] = m_exp[i];
            end else hist[i][hn[i]] = -1;
            if (hn[i] < 8191) hn[i]++;
         end
      end
   endtask
   task automatic check(string n, int got, int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d at %0t", n, got, want, $time);
      end
   endtask
   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         int ecv = (i == 0) ? int'(ec0) : (i == 1) ? int'(ec1) : int'(ec2);
         check($sformatf("u%0d_locked", i), int'(lk[i]), int'(m_lk[i]));
         check($sformatf("u%0d_exp", i), int'(ex[i]), m_exp[i]);
         check($sformatf("u%0d_mismatch", i), int'(ms[i]), int'(m_ms[i]));
         check($sformatf("u%0d_fail", i), int'(fl[i]), int'(m_fl[i]));
         check($sformatf("u%0d_err_cnt", i), ecv, m_err[i]);
         check($sformatf("u%0d_first_exp", i), int'(fe[i]), m_fe[i]);
         check($sformatf("u%0d_first_act", i), int'(fa[i]), m_fa[i]);
      end
   endtask
   task automatic step(bit e, bit r, bit k, int c0, int c1, int c2);
      en = e; crst = r; chk = k;
      cnt[0] = pick(0, c0); cnt[1] = pick(1, c1); cnt[2] = pick(2, c2);
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      step(0, 0, 1, -1, -1, -1);
      rst_n = 1'b1;
   endtask
   initial begin
      for (int i = 0; i < 5; i++) tv[i] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
      tv[5]  = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 0};
      tv[6]  = '{1, 0, 1, 0, 1, 1, 0, 0, 0, 0};
      tv[7]  = '{1, 0, 1, 1, 2, 1, 0, 0, 0, 0};
      tv[8]  = '{1, 0, 1, 2, 3, 1, 0, 0, 0, 0};
      tv[9]  = '{1, 0, 1, 5, 4, 1, 1, 1, 3, 5};
      tv[10] = '{0, 0, 1, 7, 4, 1, 1, 2, 3, 5};
      tv[11] = '{0, 0, 1, 4, 4, 1, 0, 2, 3, 5};
      tv[12] = '{1, 1, 1, 4, 0, 1, 0, 2, 3, 5};
      tv[13] = '{1, 0, 1, 0, 1, 1, 0, 2, 3, 5};
      tv[14] = '{0, 0, 1, 1, 1, 1, 0, 2, 3, 5};
      cnt[0] = '0; cnt[1] = '0; cnt[2] = '0;
      do_reset();
      check("reset_locked", int'(lk[0]), 0);
      check("reset_err", int'(ec0), 0);
      for (int i = 0; i < 15; i++) begin
         step(tv[i].en, tv[i].cr, tv[i].ck, tv[i].cnt, tv[i].cnt, -1);
         check($sformatf("tv%0d_exp", i), int'(ex[0]), tv[i].e_exp);
         check($sformatf("tv%0d_locked", i), int'(lk[0]), int'(tv[i].e_lk));
         check($sformatf("tv%0d_mismatch", i), int'(ms[0]), int'(tv[i].e_ms));
         check($sformatf("tv%0d_err", i), int'(ec0), tv[i].e_err);
         check($sformatf("tv%0d_first_exp", i), int'(fe[0]), tv[i].e_fe);
         check($sformatf("tv%0d_first_act", i), int'(fa[0]), tv[i].e_fa);
      end
      do_reset();
      step(0, 1, 1, -1, -1, -1);
      for (int i = 0; i < 17; i++) begin
         step(1, 0, 1, -1, -1, -1);
         if (i == 14) check("wrap_15", int'(ex[0]), 15);
         if (i == 15) check("wrap_0", int'(ex[0]), 0);
      end
      check("wrap_1", int'(ex[0]), 1);
      check("wrap_fail", int'(fl[0]), 0);
      check("wrap_lat3_fail", int'(fl[2]), 0);
      for (int i = 0; i < 5; i++) step(1, 0, 1, -1, -2, -1);
      check("sat_err", int'(ec1), 3);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, -1, -2, -1);
         check("chk_off_mismatch", int'(ms[1]), 0);
      end
      check("chk_off_err", int'(ec1), 3);
      do_reset();
      step(0, 1, 1, -1, -1, -1);
      for (int i = 0; i < 3; i++) step(1, 0, 1, -1, -1, -2);
      rst_n = 1'b0;
      step(1, 0, 1, -1, -1, -2);
      rst_n = 1'b1;
      check("midrst_locked", int'(lk[2]), 0);
      check("midrst_exp", int'(ex[2]), 0);
      check("midrst_fail", int'(fl[2]), 0);
      check("midrst_err", int'(ec2), 0);
      for (int i = 0; i < 3; i++) step(1, 0, 1, -2, -2, -2);
      step(1, 1, 1, -2, -2, -2);
      for (int i = 0; i < 2; i++) begin
         step(1, 0, 1, -1, -1, -2);
         check("midrst_no_stale", int'(ms[2]), 0);
      end
      check("midrst_err_after", int'(ec2), 0);
      for (int i = 0; i < 1500; i++) begin
         rst_n = ($urandom_range(63) != 0);
         step(1'($urandom_range(1)), ($urandom_range(15) == 0), ($urandom_range(7) != 0),
              ($urandom_range(7) == 0) ? -2 : -1,
              ($urandom_range(7) == 0) ? -2 : -1,
              ($urandom_range(7) == 0) ? -2 : -1);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/counter4_monitor.md
Name: counter4_monitor

Overview:
Receive-side checker for the 4-bit enable/reset pulse counter. Observes the same en/rst pulse stream and GCLK that drive the counter, plus the counter's count outputs. Keeps a cycle-accurate reference model of the count and compares it against the returned count after a fixed output latency. Reports mismatches, an error tally and the first failing pair; sits next to the counter on the test die / readout path.

Parameters:
WIDTH, 4, counter width in bits.
LAT, 1, GCLK cycles from a counter update to that value appearing on count_Pad (legal 1..4).
ERRW, 8, error-counter width.

Ports:
GCLK_Pad  input  1  system clock, all logic on rising edge
rst_n_Pad  input  1  synchronous active-low reset
en_Pad  input  1  counter enable pulse, as seen by the counter this cycle
ctr_rst_Pad  input  1  counter reset pulse, as seen by the counter this cycle
chk_en_Pad  input  1  1 = compare, 0 = model tracks but no compares
count_Pad  input  WIDTH  count value returned by the counter
locked_Pad  output  1  model synchronised (counter reset observed)
exp_Pad  output  WIDTH  current model value
mismatch_Pad  output  1  one-cycle pulse per failed compare
fail_Pad  output  1  sticky, set on first mismatch
err_cnt_Pad  output  ERRW  saturating mismatch count
first_exp_Pad  output  WIDTH  expected value of first mismatch
first_act_Pad  output  WIDTH  actual value of first mismatch

Behaviour:
- Reset (rst_n_Pad=0 at edge): state=SYNC; all outputs 0; LAT-deep expected pipeline and its valid tags cleared. Reset wins over every other input; reset mid-operation discards in-flight compares.
- States: SYNC (model unknown), TRACK.
- SYNC -> TRACK at the edge where ctr_rst_Pad=1; model loads 0; locked_Pad=1 next cycle. en_Pad ignored in SYNC. No exit from TRACK except rst_n_Pad.
- Model update in TRACK, per edge: ctr_rst_Pad=1 -> 0 (priority over en_Pad, both high -> 0); else en_Pad=1 -> exp+1 mod 2^WIDTH (2^WIDTH-1 wraps to 0); else hold.
- The new model value enters a LAT-stage shift pipeline with valid=1 (the SYNC->TRACK load also pushes 0 with valid=1). SYNC cycles push valid=0.
- Compare at each edge: pipeline output valid=1 and chk_en_Pad=1 -> compare with count_Pad. chk_en_Pad sampled at compare time; low suppresses the compare only, pipeline keeps shifting.
- Mismatch: mismatch_Pad=1 for exactly the next cycle; err_cnt_Pad +1, saturating at 2^ERRW-1; if fail_Pad=0, capture first_exp/first_act and set fail_Pad. Later mismatches do not overwrite captures.
- Match: mismatch_Pad=0, nothing else changes.
- exp_Pad shows the model register (latency 0 from its update edge, independent of LAT).
- All outputs registered; no combinational input->output paths.

Test Plan:
- Reset, then 5 en pulses without ctr_rst -> locked_Pad=0, exp_Pad=0, no compares, err_cnt_Pad=0.
- ctr_rst, then 17 en pulses, count_Pad driven correctly (LAT=1) -> exp_Pad wraps 15->0->1, mismatch_Pad never set, fail_Pad=0.
- ctr_rst and en in the same cycle, then en -> model 0 then 1; count_Pad 0,1 -> no error.
- After exp=3, force count_Pad=5 for one compare -> one-cycle mismatch_Pad, err_cnt_Pad=1, first_exp=3, first_act=5; a second fault (exp 4, act 7) -> err_cnt_Pad=2, captures stay 3/5.
- ERRW=2, 5 consecutive faults -> err_cnt_Pad saturates at 3; chk_en_Pad=0 during further faults -> no mismatch_Pad, err_cnt_Pad still 3.
- LAT=3 with in-flight values, assert rst_n_Pad=0 one cycle -> all outputs 0, state SYNC, no stale compare after release.
